// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit map, NOP encoding, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_pkg;

  // Default widths, shared with the EX-stage forwarding logic.
  localparam int DEF_XLEN = 32;
  localparam int DEF_RA_W = 5;

  // Decoded control bundle.
  localparam int CTRL_W     = 9;
  localparam int REG_WRITE  = 0;
  localparam int MEM_TO_REG = 1;
  localparam int MEM_READ   = 2;
  localparam int MEM_WRITE  = 3;
  localparam int BRANCH     = 4;
  localparam int ALU_SRC    = 5;
  localparam int ALU_OP_LSB = 6;
  localparam int ALU_OP_MSB = 7;
  localparam int JUMP       = 8;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // All-zero control bundle: writes nothing, reads nothing, never branches.
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: decoded fields in (id_*), registered fields out (ex_*).
// Latency: n/a (wiring only).
// Backpressure: n/a; stalls are signalled by the stage's write-enables.
// Modports: master = decode/execute side (drives id_*, reads ex_*),
//           slave  = id_ex_stage (reads id_*, drives ex_*).
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RA_W = DEF_RA_W
) ();

  // decode side
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic [RA_W-1:0] id_rd;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  ctrl_t           id_ctrl;
  logic [3:0]      id_funct;

  // execute side
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [RA_W-1:0] ex_rs1;
  logic [RA_W-1:0] ex_rs2;
  logic [RA_W-1:0] ex_rd;
  ctrl_t           ex_ctrl;
  logic [3:0]      ex_funct;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_ctrl, id_funct,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_funct
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2, id_ctrl, id_funct,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_funct
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard term: a load in EX whose destination a valid ID instruction reads.
// Latency: combinational.
// Backpressure: none; the caller turns the hazard into a stall.
// Ports: ex_valid/ex_mem_read/ex_rd describe the EX slot; id_* describe the
//        decode slot; lu_hazard is the one-cycle stall request.
module load_use_detect #(
  parameter int RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  output logic            lu_hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never produces a value to wait for.
  assign lu_hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                     && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and bubble counter.
// Latency: one cycle id_* -> ex_*; pc_write/if_id_write are combinational.
// Backpressure: hold freezes everything; a load-use hazard stalls PC/IF-ID for one cycle.
// Ports: clk/rst (sync, active high); bus = id_ex_stage_if slave; ex_flush kills the
//        decode slot; hold is the global stall; pc_write/if_id_write are the upstream
//        write-enables; bubble_cnt counts load-use bubbles (saturating).
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int RA_W  = DEF_RA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     bus,
  input  logic             ex_flush,
  input  logic             hold,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [RA_W-1:0] rs1_q;
  logic [RA_W-1:0] rs2_q;
  logic [RA_W-1:0] rd_q;
  ctrl_t           ctrl_q;
  logic [3:0]      funct_q;
  logic [CNT_W-1:0] cnt_q;
  logic            lu_hazard;

  load_use_detect #(.RA_W(RA_W)) u_lud (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q[MEM_READ]),
    .ex_rd       (rd_q),
    .id_valid    (bus.id_valid),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .lu_hazard   (lu_hazard)
  );

  // A flush kills the decode slot but the fetch path must still advance to the
  // redirect target, so ex_flush deliberately does not gate the write-enables.
  assign pc_write    = !(lu_hazard || hold);
  assign if_id_write = !(lu_hazard || hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= CTRL_NOP;
      funct_q    <= '0;
      cnt_q      <= '0;
    end else if (!hold) begin
      // Data/address fields load unconditionally; only valid/ctrl decide whether
      // the slot is a real instruction or a bubble.
      pc_q       <= bus.id_pc;
      rs1_data_q <= bus.id_rs1_data;
      rs2_data_q <= bus.id_rs2_data;
      imm_q      <= bus.id_imm;
      rs1_q      <= bus.id_rs1;
      rs2_q      <= bus.id_rs2;
      rd_q       <= bus.id_rd;
      funct_q    <= bus.id_funct;
      if (ex_flush || lu_hazard) begin
        valid_q <= 1'b0;
        ctrl_q  <= CTRL_NOP;
      end else begin
        valid_q <= bus.id_valid;
        ctrl_q  <= bus.id_valid ? bus.id_ctrl : CTRL_NOP;
      end
      // Flush wins over a simultaneous hazard, so that bubble is not counted.
      if (lu_hazard && !ex_flush && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_rs1_data = rs1_data_q;
  assign bus.ex_rs2_data = rs2_data_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1      = rs1_q;
  assign bus.ex_rs2      = rs2_q;
  assign bus.ex_rd       = rd_q;
  assign bus.ex_ctrl     = ctrl_q;
  assign bus.ex_funct    = funct_q;
  assign bubble_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: sequential vector table plus hazard/saturation/reset sequences.
// Latency: checks write-enables before each edge and registered outputs #1 after it.
// Backpressure: exercises hold, flush and load-use stalls.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int CNT_W = 2;
  localparam logic [8:0] RW = 9'h001;  // REG_WRITE
  localparam logic [8:0] LD = 9'h007;  // REG_WRITE | MEM_TO_REG | MEM_READ

  logic clk;
  logic rst;
  logic ex_flush;
  logic hold;
  logic pc_write;
  logic if_id_write;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();

  id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .ex_flush    (ex_flush),
    .hold        (hold),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .bubble_cnt  (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic [8:0]  ctrl;
    logic        fl;
    logic        hd;
    logic        chk_we;
    logic        we;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [4:0]  e_rd;
    logic [8:0]  e_ctrl;
    logic [1:0]  e_cnt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(
    input logic r, input logic vld, input logic [31:0] pc,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic u1, input logic u2, input logic [8:0] ctrl,
    input logic fl, input logic hd, input logic chk_we, input logic we,
    input logic e_vld, input logic [31:0] e_pc, input logic [4:0] e_rs1,
    input logic [4:0] e_rs2, input logic [4:0] e_rd, input logic [8:0] e_ctrl,
    input logic [1:0] e_cnt);
    vec_t v;
    v.rst = r; v.vld = vld; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.u1 = u1; v.u2 = u2; v.ctrl = ctrl; v.fl = fl; v.hd = hd;
    v.chk_we = chk_we; v.we = we; v.e_vld = e_vld; v.e_pc = e_pc;
    v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rd = e_rd; v.e_ctrl = e_ctrl;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  // Operand data, immediate and funct are derived from the PC so every
  // latched field can be checked against the PC the slot is expected to hold.
  function automatic logic [31:0] d1(input logic [31:0] pc); return pc ^ 32'hA5A5_0000; endfunction
  function automatic logic [31:0] d2(input logic [31:0] pc); return pc ^ 32'h5A5A_0000; endfunction
  function automatic logic [31:0] dimm(input logic [31:0] pc); return ~pc; endfunction
  function automatic logic [3:0]  dfn(input logic [31:0] pc); return pc[5:2]; endfunction

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst              = v.rst;
    ex_flush         = v.fl;
    hold             = v.hd;
    bus.id_valid     = v.vld;
    bus.id_pc        = v.pc;
    bus.id_rs1_data  = d1(v.pc);
    bus.id_rs2_data  = d2(v.pc);
    bus.id_imm       = dimm(v.pc);
    bus.id_funct     = dfn(v.pc);
    bus.id_rs1       = v.rs1;
    bus.id_rs2       = v.rs2;
    bus.id_rd        = v.rd;
    bus.id_uses_rs1  = v.u1;
    bus.id_uses_rs2  = v.u2;
    bus.id_ctrl      = v.ctrl;
    #1;
    if (v.chk_we) begin
      chk(idx, "pc_write", {31'b0, pc_write}, {31'b0, v.we});
      chk(idx, "if_id_write", {31'b0, if_id_write}, {31'b0, v.we});
    end
    @(posedge clk);
    #1;
    chk(idx, "ex_valid", {31'b0, bus.ex_valid}, {31'b0, v.e_vld});
    chk(idx, "ex_pc", bus.ex_pc, v.e_pc);
    chk(idx, "ex_rs1", {27'b0, bus.ex_rs1}, {27'b0, v.e_rs1});
    chk(idx, "ex_rs2", {27'b0, bus.ex_rs2}, {27'b0, v.e_rs2});
    chk(idx, "ex_rd", {27'b0, bus.ex_rd}, {27'b0, v.e_rd});
    chk(idx, "ex_ctrl", {23'b0, bus.ex_ctrl}, {23'b0, v.e_ctrl});
    chk(idx, "bubble_cnt", {30'b0, bubble_cnt}, {30'b0, v.e_cnt});
    chk(idx, "ex_rs1_data", bus.ex_rs1_data, v.rst ? 32'h0 : d1(v.e_pc));
    chk(idx, "ex_rs2_data", bus.ex_rs2_data, v.rst ? 32'h0 : d2(v.e_pc));
    chk(idx, "ex_imm", bus.ex_imm, v.rst ? 32'h0 : dimm(v.e_pc));
    chk(idx, "ex_funct", {28'b0, bus.ex_funct}, v.rst ? 32'h0 : {28'b0, dfn(v.e_pc)});
  endtask

  vec_t tbl[21];

  initial begin
    logic [1:0] exp_cnt;
    rst = 1'b1; ex_flush = 1'b0; hold = 1'b0;

    //            rst vld pc      rs1 rs2 rd u1 u2 ctrl fl hd cw we  evld epc     ers1 ers2 erd ectrl cnt
    // reset (first edge: state unknown before it, so write-enables checked from the second)
    tbl[0]  = mk(1, 0, 32'h0,   0,  0,  0, 0, 0, 9'h0, 0, 0, 0, 1,  0, 32'h0,   0, 0, 0,  9'h0, 0);
    tbl[1]  = mk(1, 1, 32'h100, 0,  0,  0, 0, 0, RW,   0, 0, 1, 1,  0, 32'h0,   0, 0, 0,  9'h0, 0);
    // normal flow, then lw x7
    tbl[2]  = mk(0, 1, 32'h100, 1,  2,  5, 1, 1, RW,   0, 0, 1, 1,  1, 32'h100, 1, 2, 5,  RW,   0);
    tbl[3]  = mk(0, 1, 32'h104, 1,  0,  7, 1, 0, LD,   0, 0, 1, 1,  1, 32'h104, 1, 0, 7,  LD,   0);
    // add x8,x7,x2: load-use on rs1 -> bubble, then the held instruction enters
    tbl[4]  = mk(0, 1, 32'h108, 7,  2,  8, 1, 1, RW,   0, 0, 1, 0,  0, 32'h108, 7, 2, 8,  9'h0, 1);
    tbl[5]  = mk(0, 1, 32'h108, 7,  2,  8, 1, 1, RW,   0, 0, 1, 1,  1, 32'h108, 7, 2, 8,  RW,   1);
    // lw x0 followed by a reader of x0: no hazard
    tbl[6]  = mk(0, 1, 32'h10c, 1,  0,  0, 1, 0, LD,   0, 0, 1, 1,  1, 32'h10c, 1, 0, 0,  LD,   1);
    tbl[7]  = mk(0, 1, 32'h110, 0,  0,  9, 1, 1, RW,   0, 0, 1, 1,  1, 32'h110, 0, 0, 9,  RW,   1);
    // lw x7 followed by rs2=x7 with uses_rs2=0: no hazard
    tbl[8]  = mk(0, 1, 32'h114, 1,  0,  7, 1, 0, LD,   0, 0, 1, 1,  1, 32'h114, 1, 0, 7,  LD,   1);
    tbl[9]  = mk(0, 1, 32'h118, 3,  7, 10, 1, 0, RW,   0, 0, 1, 1,  1, 32'h118, 3, 7, 10, RW,   1);
    // hazard on rs2 together with flush: flush wins, no count
    tbl[10] = mk(0, 1, 32'h11c, 1,  0,  7, 1, 0, LD,   0, 0, 1, 1,  1, 32'h11c, 1, 0, 7,  LD,   1);
    tbl[11] = mk(0, 1, 32'h120, 4,  7, 11, 1, 1, RW,   1, 0, 1, 0,  0, 32'h120, 4, 7, 11, 9'h0, 1);
    // hold for three cycles with changing inputs, then hold+flush, then flush on release
    tbl[12] = mk(0, 1, 32'h124, 5,  6, 12, 1, 1, RW,   0, 0, 1, 1,  1, 32'h124, 5, 6, 12, RW,   1);
    tbl[13] = mk(0, 1, 32'h128, 9,  9, 13, 1, 1, LD,   0, 1, 1, 0,  1, 32'h124, 5, 6, 12, RW,   1);
    tbl[14] = mk(0, 0, 32'h12c, 10, 10,14, 0, 0, 9'h0, 0, 1, 1, 0,  1, 32'h124, 5, 6, 12, RW,   1);
    tbl[15] = mk(0, 1, 32'h130, 11, 11,15, 1, 1, RW,   0, 1, 1, 0,  1, 32'h124, 5, 6, 12, RW,   1);
    tbl[16] = mk(0, 1, 32'h134, 12, 12,16, 1, 1, RW,   1, 1, 1, 0,  1, 32'h124, 5, 6, 12, RW,   1);
    tbl[17] = mk(0, 1, 32'h138, 6,  3, 14, 1, 1, RW,   1, 0, 1, 1,  0, 32'h138, 6, 3, 14, 9'h0, 1);
    // invalid decode slot: control gated to NOP, and it cannot raise a hazard
    tbl[18] = mk(0, 0, 32'h13c, 0,  0, 15, 0, 0, RW,   0, 0, 1, 1,  0, 32'h13c, 0, 0, 15, 9'h0, 1);
    tbl[19] = mk(0, 1, 32'h140, 1,  0,  7, 1, 0, LD,   0, 0, 1, 1,  1, 32'h140, 1, 0, 7,  LD,   1);
    tbl[20] = mk(0, 0, 32'h144, 7,  7,  8, 1, 1, RW,   0, 0, 1, 1,  0, 32'h144, 7, 7, 8,  9'h0, 1);

    for (int i = 0; i < 21; i++) apply(i, tbl[i]);

    // Saturation: five more load-use bubbles on a 2-bit counter.
    exp_cnt = 2'd1;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] pc;
      pc = 32'h200 + 32'(k) * 32'h10;
      apply(100 + 2*k, mk(0, 1, pc, 1, 0, 7, 1, 0, LD, 0, 0, 1, 1,
                          1, pc, 1, 0, 7, LD, exp_cnt));
      exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      apply(101 + 2*k, mk(0, 1, pc + 4, 7, 2, 8, 1, 1, RW, 0, 0, 1, 0,
                          0, pc + 4, 7, 2, 8, 9'h0, exp_cnt));
    end

    // Reset while a hazard is active: empty pipeline, then normal entry.
    apply(200, mk(0, 1, 32'h300, 1, 0, 7, 1, 0, LD, 0, 0, 1, 1,
                  1, 32'h300, 1, 0, 7, LD, 2'd3));
    apply(201, mk(1, 1, 32'h304, 2, 7, 8, 0, 1, RW, 0, 0, 1, 0,
                  0, 32'h0, 0, 0, 0, 9'h0, 2'd0));
    apply(202, mk(0, 1, 32'h304, 2, 7, 8, 0, 1, RW, 0, 0, 1, 1,
                  1, 32'h304, 2, 7, 8, RW, 2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
